spline_playback: RTL and testbench
==================================

# spline_playback

Streaming reader for the spline interpolator's packed `approximation` vector. On a load strobe it captures all 10*(N-1) signed 8-bit interpolated samples. It then releases them one at a time, in index order, to the lane-change actuator path over a valid/ready handshake. A programmable pacing interval separates successive samples.

## Interface
- `N`, default 2: number of spline data points; total samples `TOTAL = 10*(N-1)`.
- `TICK_DIV`, default 4: clock cycles of pacing before each sample is presented; legal range 1..255.
- `clock` input, 1 bit: single clock, rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `load` input, 1 bit: capture `approximation` and start playback from index 0.
- `abort` input, 1 bit: synchronous stop; return to IDLE.
- `approximation` input, `10*(N-1)*8` bits: packed samples; sample k is at bits `[k*8 +: 8]`.
- `sample_out` output, 8 bits: signed current sample.
- `sample_valid` output, 1 bit: `sample_out` is presented.
- `sample_ready` input, 1 bit: downstream accepts the sample.
- `sample_index` output, 8 bits: index of the sample in `sample_out`.
- `busy` output, 1 bit: high in every state except IDLE.
- `done` output, 1 bit: one-cycle pulse after the final sample is accepted.

## Operation
- States:
  - IDLE: wait for `load`.
  - PACE: count down the pacing interval.
  - PRESENT: hold `sample_valid`.
- Capture: `load` sampled high copies `approximation` into an internal buffer of `TOTAL` × 8 bits, sets index to 0, sets the pace counter to `TICK_DIV-1`, and enters PACE. Changes on the `approximation` input after capture have no effect.
- PACE:
  - The counter decrements on each edge.
  - On the edge where the counter equals 0, the block enters PRESENT, drives `sample_out = buf[index]`, and drives `sample_valid = 1`.
- PRESENT:
  - `sample_out` and `sample_index` stay stable while `sample_valid && !sample_ready`.
  - On handshake (`valid && ready`) with `index < TOTAL-1`: increment index, reload the counter to `TICK_DIV-1`, enter PACE, and drop `sample_valid`.
  - On handshake with `index == TOTAL-1`: go to IDLE and pulse `done` for one cycle.
- Priority: `abort` > `load` > handshake/pacing.
  - `abort` from any state goes to IDLE with `sample_valid = 0`, no `done`, and the buffer retained.
  - `load` while busy restarts from index 0 with the newly captured vector. Any coincident handshake is discarded and no `done` is generated.
- `sample_ready` outside PRESENT is ignored.
- Arithmetic:
  - Samples are passed through unchanged as two's complement; no scaling.
  - `sample_index` is 8 bits; elaboration fails if `TOTAL > 256`.

## Timing
- Reset values: `sample_out = 0`, `sample_valid = 0`, `sample_index = 0`, `busy = 0`, `done = 0`, buffer = 0, state IDLE, counter 0.
- Latency:
  - `load` at edge E0 produces `sample_valid` high after edge E0+`TICK_DIV`.
  - Each following sample appears `TICK_DIV` cycles after the edge that accepted the previous one.
  - `TICK_DIV = 1` presents a sample one cycle after each acceptance.
- Throughput: one sample per `TICK_DIV+1` cycles when `sample_ready` is held high.
- `busy` rises the cycle after `load`. On the final acceptance, `busy` falls and `done` rises in the same cycle.
- `reset_n` asserted mid-playback immediately forces all reset values. Playback does not resume after release.

## Configuration
- `SPLINE_PLAYBACK_LOOP_EN`:
  - Defined: after the final acceptance the block wraps `index` to 0, reloads pacing, and stays busy. `done` still pulses once per wrap. Playback repeats until `abort`, `load`, or reset.
  - Undefined: one-shot playback as described under Operation, returning to IDLE.

## Structure
- Shared package `spline_pkg`:
  - `SAMPLE_W = 8`
  - `SAMPLES_PER_SEG = 10`
  - state enum `playback_state_t` with values IDLE, PACE, PRESENT
  - function `total_samples(N)`
- Sub-module `pace_counter`: a loadable down-counter of width `$clog2(TICK_DIV+1)` with a `zero` flag. It is reused by other paced blocks on the actuator path.
- The buffer is a register array; no RAM inference.

## Test plan
- N=2, TICK_DIV=4, `sample_ready` high, samples 0..9 = 10,20,…,100: `sample_valid` first rises 4 cycles after `load`. Indices 0..9 appear every 5 cycles. `done` pulses after index 9 and `busy` drops.
- Backpressure: `sample_ready` held low for 7 cycles at index 3 (value −5): `sample_out = −5` and `sample_index = 3` stay stable all 7 cycles, with no skip or duplicate afterwards.
- Reload mid-playback: at index 6, `load` with a new vector (all 0x7F) coincides with a handshake. Playback restarts at index 0 outputting 127, with no `done` for the first run.
- `abort` at index 2 in PRESENT: IDLE next cycle, with `sample_valid = 0`, `busy = 0`, and `done = 0`.
- `reset_n` pulsed low at index 5: all outputs are 0 immediately. After release no sample is presented until a new `load`.
- With `SPLINE_PLAYBACK_LOOP_EN`, N=3 (20 samples): after index 19 the next presented sample is index 0. `done` pulses once per wrap and `busy` stays 1.

Source files
------------

// File: rtl/spline_pkg.sv
// rtl/spline_pkg.sv - shared sample widths, playback state encoding and sizing helper
package spline_pkg;

  localparam int SAMPLE_W        = 8;
  localparam int SAMPLES_PER_SEG = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PACE    = 2'd1,
    PRESENT = 2'd2
  } playback_state_t;

  // Number of interpolated samples produced for n spline data points
  function automatic int total_samples(input int n);
    return SAMPLES_PER_SEG * (n - 1);
  endfunction

endpackage

// File: rtl/spline_playback_if.sv
// rtl/spline_playback_if.sv - sample stream handshake between playback and actuator path
interface spline_playback_if;
  import spline_pkg::*;

  logic signed [SAMPLE_W-1:0] sample_out;
  logic                       sample_valid;
  logic                       sample_ready;
  logic [7:0]                 sample_index;

  modport master (
    output sample_out,
    output sample_valid,
    output sample_index,
    input  sample_ready
  );

  modport slave (
    input  sample_out,
    input  sample_valid,
    input  sample_index,
    output sample_ready
  );

endinterface

// File: rtl/spline_playback_pace_counter.sv
// rtl/spline_playback_pace_counter.sv - loadable down-counter with zero flag for paced blocks
module pace_counter #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load takes priority; decrement stops at zero so an idle counter stays parked there
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/spline_playback.sv
// rtl/spline_playback.sv - paced valid/ready playback of captured spline samples (option: SPLINE_PLAYBACK_LOOP_EN)
module spline_playback
  import spline_pkg::*;
#(
  parameter int N        = 2,
  parameter int TICK_DIV = 4
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  load,
  input  logic                                  abort,
  input  logic [total_samples(N)*SAMPLE_W-1:0]  approximation,
  spline_playback_if.master                     stream,
  output logic                                  busy,
  output logic                                  done
);

  localparam int TOTAL = total_samples(N);
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int CNT_W = $clog2(TICK_DIV + 1);
  localparam logic [7:0]       LAST_IDX = 8'(TOTAL - 1);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(TICK_DIV - 1);

  if (TOTAL > 256) begin : g_total_check
    $error("spline_playback: TOTAL exceeds the 8-bit sample_index range");
  end
  if (TICK_DIV < 1 || TICK_DIV > 255) begin : g_tick_check
    $error("spline_playback: TICK_DIV must be within 1..255");
  end

  playback_state_t            state;
  logic signed [SAMPLE_W-1:0] buffer [TOTAL];
  logic [7:0]                 idx;
  logic signed [SAMPLE_W-1:0] out_q;
  logic                       valid_q;
  logic                       cnt_load;
  logic                       cnt_dec;
  logic                       cnt_zero;

  assign stream.sample_out   = out_q;
  assign stream.sample_valid = valid_q;
  assign stream.sample_index = idx;

  // Counter reloads on capture and on every accepted sample, and counts down only while pacing
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (!abort) begin
      if (load) begin
        cnt_load = 1'b1;
      end else if (state == PRESENT && stream.sample_ready) begin
        cnt_load = 1'b1;
      end else if (state == PACE) begin
        cnt_dec = 1'b1;
      end
    end
  end

  pace_counter #(.W(CNT_W)) u_pace (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (cnt_load),
    .load_value (RELOAD),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  // Playback FSM: abort beats load beats handshake/pacing; all outputs registered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      idx     <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int k = 0; k < TOTAL; k++) begin
        buffer[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        valid_q <= 1'b0;
        busy    <= 1'b0;
      end else if (load) begin
        for (int k = 0; k < TOTAL; k++) begin
          buffer[k] <= approximation[k*SAMPLE_W +: SAMPLE_W];
        end
        idx     <= '0;
        state   <= PACE;
        valid_q <= 1'b0;
        busy    <= 1'b1;
      end else begin
        case (state)
          PACE: begin
            if (cnt_zero) begin
              state   <= PRESENT;
              out_q   <= buffer[idx[IDX_W-1:0]];
              valid_q <= 1'b1;
            end
          end
          PRESENT: begin
            if (stream.sample_ready) begin
              valid_q <= 1'b0;
              if (idx == LAST_IDX) begin
                done <= 1'b1;
`ifdef SPLINE_PLAYBACK_LOOP_EN
                idx   <= '0;
                state <= PACE;
`else
                state <= IDLE;
                busy  <= 1'b0;
`endif
              end else begin
                idx   <= idx + 8'd1;
                state <= PACE;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spline_playback.sv
// tb/tb_spline_playback.sv - self-checking bench for spline_playback (option: SPLINE_PLAYBACK_LOOP_EN)
module tb_spline_playback;
  import spline_pkg::*;

`ifdef SPLINE_PLAYBACK_LOOP_EN
  localparam int N = 3;
`else
  localparam int N = 2;
`endif
  localparam int TICK_DIV = 4;
  localparam int TOTAL    = 10 * (N - 1);

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic load = 1'b0;
  logic abort = 1'b0;
  logic [TOTAL*8-1:0] approximation = '0;
  logic busy;
  logic done;

  spline_playback_if sif ();

  spline_playback #(.N(N), .TICK_DIV(TICK_DIV)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .load          (load),
    .abort         (abort),
    .approximation (approximation),
    .stream        (sif),
    .busy          (busy),
    .done          (done)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  logic signed [7:0] vec [TOTAL];

  typedef struct {
    int   c;
    logic v;
    logic b;
    logic d;
    int   idx;
    int   val;
  } row_t;
  row_t tbl [8];

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  // Called at a falling edge; returns at the falling edge after the capturing rising edge
  task automatic do_load();
    for (int k = 0; k < TOTAL; k++) approximation[k*8 +: 8] = vec[k];
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    approximation = {TOTAL{8'hA5}};
  endtask

  task automatic ramp();
    for (int k = 0; k < TOTAL; k++) vec[k] = 8'(10 * (k + 1));
  endtask

  task automatic wait_idx(input int want);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (sif.sample_valid && int'(sif.sample_index) == want) ok = 1;
      else @(negedge clock);
    end
    check("wait_for_index", int'(ok), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ti;
    int got [$];
    bit seen_done;
    bit seen_valid;
    bit playing;
    bit exp_done;
    bit ev;
    bit hs;
    int kk;
    int s;
    int dones;
    bit busy_low;

    tbl[0] = '{c: 1,  v: 0, b: 1, d: 0, idx: 0, val: 0};
    tbl[1] = '{c: 3,  v: 0, b: 1, d: 0, idx: 0, val: 0};
    tbl[2] = '{c: 4,  v: 1, b: 1, d: 0, idx: 0, val: 10};
    tbl[3] = '{c: 5,  v: 0, b: 1, d: 0, idx: 0, val: 0};
    tbl[4] = '{c: 9,  v: 1, b: 1, d: 0, idx: 1, val: 20};
    tbl[5] = '{c: 49, v: 1, b: 1, d: 0, idx: 9, val: 100};
    tbl[6] = '{c: 50, v: 0, b: 0, d: 1, idx: 0, val: 0};
    tbl[7] = '{c: 51, v: 0, b: 0, d: 0, idx: 0, val: 0};

    sif.sample_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_valid", int'(sif.sample_valid), 0);
    check("reset_out",   int'(sif.sample_out), 0);
    check("reset_index", int'(sif.sample_index), 0);
    check("reset_busy",  int'(busy), 0);
    check("reset_done",  int'(done), 0);
    reset_n = 1'b1;
    @(negedge clock);

`ifndef SPLINE_PLAYBACK_LOOP_EN
    // Ramp with ready held high, checked against timeline table
    ramp();
    sif.sample_ready = 1'b1;
    do_load();
    ti = 0;
    for (int c = 1; c <= 51; c++) begin
      @(negedge clock);
      if (ti < 8 && tbl[ti].c == c) begin
        check($sformatf("tbl%0d_valid", ti), int'(sif.sample_valid), int'(tbl[ti].v));
        check($sformatf("tbl%0d_busy", ti),  int'(busy), int'(tbl[ti].b));
        check($sformatf("tbl%0d_done", ti),  int'(done), int'(tbl[ti].d));
        if (tbl[ti].v) begin
          check($sformatf("tbl%0d_index", ti), int'(sif.sample_index), tbl[ti].idx);
          check($sformatf("tbl%0d_out", ti),   int'(sif.sample_out), tbl[ti].val);
        end
        ti++;
      end
    end

    // Backpressure at index 3
    ramp();
    vec[3] = -8'sd5;
    do_load();
    wait_idx(3);
    sif.sample_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      check("bp_valid", int'(sif.sample_valid), 1);
      check("bp_index", int'(sif.sample_index), 3);
      check("bp_out",   int'(sif.sample_out), -5);
    end
    sif.sample_ready = 1'b1;
    got.delete();
    seen_done = 0;
    for (int i = 0; i < 100 && !seen_done; i++) begin
      if (sif.sample_valid) got.push_back(int'(sif.sample_index));
      @(negedge clock);
      if (done) seen_done = 1;
    end
    check("bp_accept_count", got.size(), 7);
    for (int j = 0; j < got.size(); j++) check("bp_accept_order", got[j], 3 + j);
    check("bp_done", int'(seen_done), 1);

    // Reload coinciding with a handshake at index 6
    ramp();
    do_load();
    wait_idx(6);
    for (int k = 0; k < TOTAL; k++) vec[k] = 8'sh7F;
    do_load();
    seen_done = 0;
    seen_valid = 0;
    for (int i = 0; i < 20 && !seen_valid; i++) begin
      if (done) seen_done = 1;
      if (sif.sample_valid) seen_valid = 1;
      else @(negedge clock);
    end
    check("reload_no_done", int'(seen_done), 0);
    check("reload_valid", int'(seen_valid), 1);
    check("reload_index", int'(sif.sample_index), 0);
    check("reload_out", int'(sif.sample_out), 127);

    // Abort in PRESENT at index 2
    ramp();
    do_load();
    wait_idx(2);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_valid", int'(sif.sample_valid), 0);
    check("abort_busy",  int'(busy), 0);
    check("abort_done",  int'(done), 0);
    @(negedge clock);
    check("abort_done_after", int'(done), 0);
    check("abort_valid_after", int'(sif.sample_valid), 0);

    // Asynchronous reset at index 5
    ramp();
    do_load();
    wait_idx(5);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", int'(sif.sample_valid), 0);
    check("arst_out",   int'(sif.sample_out), 0);
    check("arst_index", int'(sif.sample_index), 0);
    check("arst_busy",  int'(busy), 0);
    check("arst_done",  int'(done), 0);
    @(negedge clock);
    reset_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (sif.sample_valid || busy) seen_valid = 1;
    end
    check("arst_no_resume", int'(seen_valid), 0);
`else
    // Continuous looping with ready held high
    for (int k = 0; k < TOTAL; k++) vec[k] = 8'($urandom);
    sif.sample_ready = 1'b1;
    do_load();
    got.delete();
    dones = 0;
    busy_low = 0;
    for (int c = 0; c < 210; c++) begin
      if (sif.sample_valid) got.push_back(int'(sif.sample_index));
      if (done) dones++;
      if (!busy) busy_low = 1;
      @(negedge clock);
    end
    check("loop_accept_count", got.size(), 42);
    for (int j = 0; j < got.size(); j++) check("loop_index_order", got[j], j % TOTAL);
    check("loop_wrap_index", got[TOTAL], 0);
    check("loop_done_count", dones, 2);
    check("loop_busy_held", int'(busy_low), 0);
    abort = 1'b1;
    sif.sample_ready = 1'b0;
    @(negedge clock);
    abort = 1'b0;
    check("loop_abort_busy", int'(busy), 0);
`endif

    // Random ready against a timeline model of the playback rules
    for (int t = 0; t < 4; t++) begin
      sif.sample_ready = 1'b0;
      for (int k = 0; k < TOTAL; k++) vec[k] = 8'($urandom);
      do_load();
      playing = 1;
      kk = 0;
      s = 0;
      exp_done = 0;
      for (int cyc = 0; cyc < 300 && playing; cyc++) begin
        ev = playing && (s >= TICK_DIV);
        check("rnd_valid", int'(sif.sample_valid), int'(ev));
        check("rnd_busy",  int'(busy), int'(playing));
        check("rnd_done",  int'(done), int'(exp_done));
        if (ev) begin
          check("rnd_index", int'(sif.sample_index), kk);
          check("rnd_out",   int'(sif.sample_out), int'(vec[kk]));
        end
        sif.sample_ready = 1'($urandom_range(0, 1));
        hs = ev && sif.sample_ready;
        @(negedge clock);
        exp_done = 0;
        if (hs) begin
          s = 0;
          if (kk == TOTAL - 1) begin
            exp_done = 1;
            kk = 0;
`ifndef SPLINE_PLAYBACK_LOOP_EN
            playing = 0;
`endif
          end else begin
            kk++;
          end
        end else if (playing) begin
          s++;
        end
      end
      check("rnd_end_done", int'(done), int'(exp_done));
      check("rnd_end_busy", int'(busy), int'(playing));
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      check("rnd_abort_valid", int'(sif.sample_valid), 0);
      check("rnd_abort_busy",  int'(busy), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
